key_filter_tick: RTL



---
 rtl/key_filter_tick_if.sv | 20 ++
 rtl/key_filter_tick.sv | 129 ++++++++++++
 2 files changed

// File: rtl/key_filter_tick_if.sv
// Key-filter signal bundle: tick enable and raw key in, debounced level and
// event pulses out. Clock and reset stay outside as plain ports.
interface key_filter_tick_if;
  logic tick_1k;
  logic key_in;
  logic key_state;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    output tick_1k, key_in,
    input  key_state, key_press, key_release, key_long
  );

  modport slave (
    input  tick_1k, key_in,
    output key_state, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_filter_tick.sv
// Push-button debouncer paced by a 1 kHz enable tick: debounced level,
// press/release event pulses and a one-shot long-press pulse.
module key_filter_tick #(
  parameter int FILTER_MS = 20,
  parameter int LONG_MS   = 1000,
  parameter int CNT_W     = 10
) (
  input logic        Clk,
  input logic        Reset,
  key_filter_tick_if.slave kif
);

  typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} state_t;

  localparam logic [7:0]       FILT_LAST = 8'(FILTER_MS - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_MS);

  state_t           state, state_nxt;
  logic [7:0]       filt_cnt, filt_nxt;
  logic [CNT_W-1:0] long_cnt, long_nxt;
  logic             key_m, key_s;
  logic             lvl_q, lvl_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;

  // Two-flop synchronizer; idles high so reset never looks like a press.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= kif.key_in;
      key_s <= key_m;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      filt_cnt <= '0;
      long_cnt <= '0;
      lvl_q    <= 1'b1;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      filt_cnt <= filt_nxt;
      long_cnt <= long_nxt;
      lvl_q    <= lvl_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      long_q   <= long_d;
    end
  end

  always_comb begin
    state_nxt = state;
    filt_nxt  = filt_cnt;
    long_nxt  = long_cnt;
    lvl_d     = lvl_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    long_d    = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = PRESS_FILT;
          filt_nxt  = '0;
        end
      end
      PRESS_FILT: begin
        // Key level is checked before the tick so a coincident bounce wins.
        if (key_s) begin
          state_nxt = IDLE;
          filt_nxt  = '0;
        end else if (kif.tick_1k) begin
          if (filt_cnt == FILT_LAST) begin
            state_nxt = DOWN;
            filt_nxt  = '0;
            long_nxt  = '0;
            lvl_d     = 1'b0;
            press_d   = 1'b1;
          end else begin
            filt_nxt = filt_cnt + 8'd1;
          end
        end
      end
      DOWN: begin
        if (key_s) begin
          state_nxt = REL_FILT;
          filt_nxt  = '0;
        end else if (kif.tick_1k && long_cnt != LONG_MAX) begin
          // Saturation at LONG_MAX makes key_long one-shot per press.
          long_nxt = long_cnt + 1'b1;
          long_d   = (long_cnt == LONG_LAST);
        end
      end
      REL_FILT: begin
        // long_cnt is left untouched here so a release glitch only pauses it.
        if (!key_s) begin
          state_nxt = DOWN;
          filt_nxt  = '0;
        end else if (kif.tick_1k) begin
          if (filt_cnt == FILT_LAST) begin
            state_nxt = IDLE;
            filt_nxt  = '0;
            lvl_d     = 1'b1;
            rel_d     = 1'b1;
          end else begin
            filt_nxt = filt_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        filt_nxt  = '0;
      end
    endcase
  end

  assign kif.key_state   = lvl_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = rel_q;
  assign kif.key_long    = long_q;

endmodule
